// File: rtl/instruction_decode_queue_if.sv
// ----------------------------------------------------------------------------
// instruction_decode_queue_if
// Host-side write handshake of the instruction decode queue.
//
// Signals:
//   instr_valid_i  host offers a raw 64-bit instruction word
//   instr_word_i   raw instruction word
//   instr_ready_o  queue accepts the word this cycle
//
// Handshake: a word transfers on every rising clock edge where
// instr_valid_i and instr_ready_o are both 1. While instr_ready_o is 0 the
// host must hold instr_valid_i and instr_word_i stable. instr_ready_o never
// depends combinationally on instr_valid_i.
//
// Modports:
//   master  host side (drives valid/word)
//   slave   queue side (drives ready)
// ----------------------------------------------------------------------------
interface instruction_decode_queue_if;
    logic        instr_valid_i;
    logic [63:0] instr_word_i;
    logic        instr_ready_o;

    modport master (
        output instr_valid_i,
        output instr_word_i,
        input  instr_ready_o
    );

    modport slave (
        input  instr_valid_i,
        input  instr_word_i,
        output instr_ready_o
    );
endinterface

// File: rtl/instruction_decode_queue.sv
// ----------------------------------------------------------------------------
// instruction_decode_queue
// FIFO of decoded TPU instructions. Raw 64-bit words are decoded when they
// are written; the head entry is presented show-ahead to the consumer.
//
// Parameters:
//   MUL_SIZE  systolic array edge (power of two, >= 2)
//   IQ_DEPTH  number of queue entries (power of two, >= 2)
//
// Ports:
//   clk_i                  clock, rising edge
//   rst_i                  synchronous active-high reset
//   instr_if (slave)       host write handshake (valid / word / ready)
//   read_instruction_i     consumer pops the head entry
//   decoded_instruction_o  head entry (all zeros while empty)
//   iq_empty_o             no valid entry at head
//   iq_count_o             current occupancy
//   err_illegal_o          one-cycle pulse after an illegal word is consumed
//
// Optional feature, macro IQ_ILLEGAL_CHECK_EN:
//   defined   -> words with a zero dimension or nonzero reserved bits are
//                consumed but not stored, and err_illegal_o pulses.
//   undefined -> every accepted word is stored; err_illegal_o is tied 0.
// ----------------------------------------------------------------------------
package tpu_package;
    parameter int MUL_SIZE = 16;

    typedef struct packed {
        logic [2:0]  mac_op;
        logic [7:0]  v_dim;
        logic [7:0]  u_dim;
        logic [7:0]  iter_dim;
        logic [11:0] ub_rd_addr;
        logic [11:0] ub_wr_addr;
        logic [6:0]  v_dim1;
        logic [6:0]  u_dim1;
        logic [6:0]  iter_dim1;
    } decoded_instr_t;
endpackage

module instruction_decode_queue #(
    parameter int MUL_SIZE = tpu_package::MUL_SIZE,
    parameter int IQ_DEPTH = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    instruction_decode_queue_if.slave   instr_if,
    input  logic                        read_instruction_i,
    output tpu_package::decoded_instr_t decoded_instruction_o,
    output logic                        iq_empty_o,
    output logic [$clog2(IQ_DEPTH):0]   iq_count_o,
    output logic                        err_illegal_o
);
    localparam int PTR_W = $clog2(IQ_DEPTH);
    localparam int SHIFT = $clog2(MUL_SIZE);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(IQ_DEPTH);

    // Tile count minus one. The subtraction is done 32 bits wide so that a
    // zero dimension wraps to all ones and truncates to 7'h7F.
    function automatic logic [6:0] tiles_m1(input logic [7:0] dim);
        logic [31:0] t;
        t = (32'(dim) - 32'd1) >> SHIFT;
        return t[6:0];
    endfunction

    tpu_package::decoded_instr_t mem [IQ_DEPTH];
    tpu_package::decoded_instr_t wr_entry;

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic [63:0]      word;
    logic             accept;
    logic             word_illegal;
    logic             push;
    logic             pop;

    assign word = instr_if.instr_word_i;

    always_comb begin
        wr_entry            = '0;
        wr_entry.mac_op     = word[2:0];
        wr_entry.v_dim      = word[10:3];
        wr_entry.u_dim      = word[18:11];
        wr_entry.iter_dim   = word[26:19];
        wr_entry.ub_rd_addr = word[38:27];
        wr_entry.ub_wr_addr = word[50:39];
        wr_entry.v_dim1     = tiles_m1(word[10:3]);
        wr_entry.u_dim1     = tiles_m1(word[18:11]);
        wr_entry.iter_dim1  = tiles_m1(word[26:19]);
    end

`ifdef IQ_ILLEGAL_CHECK_EN
    assign word_illegal = (word[10:3] == 8'd0) || (word[18:11] == 8'd0) ||
                          (word[26:19] == 8'd0) || (word[63:51] != 13'd0);
`else
    logic unused_rsvd;
    assign unused_rsvd  = ^word[63:51];
    assign word_illegal = 1'b0;
`endif

    // Ready depends only on occupancy, so a pop on a full queue frees a slot
    // for the following cycle, never the current one.
    assign instr_if.instr_ready_o = (count != FULL_COUNT);
    assign accept = instr_if.instr_valid_i && instr_if.instr_ready_o;
    assign push   = accept && !word_illegal;
    assign pop    = read_instruction_i && (count != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; the read side masks it while the queue is empty.
    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

`ifdef IQ_ILLEGAL_CHECK_EN
    logic err_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept && word_illegal;
        end
    end
    assign err_illegal_o = err_q;
`else
    assign err_illegal_o = 1'b0;
`endif

    assign iq_count_o            = count;
    assign iq_empty_o            = (count == '0);
    assign decoded_instruction_o = iq_empty_o ? '0 : mem[rd_ptr];
endmodule

// File: tb/tb_instruction_decode_queue.sv
module tb_instruction_decode_queue;
    import tpu_package::*;

    localparam int DEPTH = 8;
    localparam int MUL   = 16;
    localparam int W     = $bits(decoded_instr_t);
`ifdef IQ_ILLEGAL_CHECK_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_i;
    logic           read_i;
    decoded_instr_t dec;
    logic           empty;
    logic [3:0]     count;
    logic           err;

    instruction_decode_queue_if iq_if ();

    instruction_decode_queue #(
        .MUL_SIZE(MUL),
        .IQ_DEPTH(DEPTH)
    ) dut (
        .clk_i                (clk),
        .rst_i                (rst_i),
        .instr_if             (iq_if.slave),
        .read_instruction_i   (read_i),
        .decoded_instruction_o(dec),
        .iq_empty_o           (empty),
        .iq_count_o           (count),
        .err_illegal_o        (err)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    logic         exp_err;
    bit           checking;
    int           vec_count;
    int           miss_count;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [63:0] mk(input int mac, input int v, input int u,
                                       input int it, input int ra, input int wa);
        logic [63:0] w;
        w = '0;
        w[2:0]   = 3'(mac);
        w[10:3]  = 8'(v);
        w[18:11] = 8'(u);
        w[26:19] = 8'(it);
        w[38:27] = 12'(ra);
        w[50:39] = 12'(wa);
        return w;
    endfunction

    // Number of MUL-wide tiles minus one; a zero dimension yields all ones.
    function automatic logic [6:0] model_tiles(input int dim);
        if (dim == 0) return 7'h7F;
        return 7'((dim - 1) / MUL);
    endfunction

    function automatic decoded_instr_t model_decode(input logic [63:0] w);
        decoded_instr_t d;
        d.mac_op     = w[2:0];
        d.v_dim      = w[10:3];
        d.u_dim      = w[18:11];
        d.iter_dim   = w[26:19];
        d.ub_rd_addr = w[38:27];
        d.ub_wr_addr = w[50:39];
        d.v_dim1     = model_tiles(int'(w[10:3]));
        d.u_dim1     = model_tiles(int'(w[18:11]));
        d.iter_dim1  = model_tiles(int'(w[26:19]));
        return d;
    endfunction

    function automatic bit model_illegal(input logic [63:0] w);
        return (w[10:3] == 0) || (w[18:11] == 0) || (w[26:19] == 0) || (w[63:51] != 0);
    endfunction

    // ---------------- driver ----------------
    task automatic step(input logic v, input logic [63:0] w, input logic rd, input logic rs);
        bit do_acc;
        bit do_pop;
        bit ill;
        iq_if.instr_valid_i = v;
        iq_if.instr_word_i  = w;
        read_i              = rd;
        rst_i               = rs;
        @(posedge clk);
        if (rs) begin
            exp_q.delete();
            exp_err = 1'b0;
        end else begin
            do_acc = v && (exp_q.size() < DEPTH);
            do_pop = rd && (exp_q.size() > 0);
            ill    = ILL_EN && do_acc && model_illegal(w);
            if (do_pop) void'(exp_q.pop_front());
            if (do_acc && !ill) exp_q.push_back(model_decode(w));
            exp_err = ill;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 64'd0, 1'b0, 1'b0);
    endtask

    task automatic pop_one();
        step(1'b0, 64'd0, 1'b1, 1'b0);
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (checking) begin
            chk("count", count, exp_q.size());
            chk("empty", empty, exp_q.size() == 0);
            chk("ready", iq_if.instr_ready_o, exp_q.size() != DEPTH);
            chk("err", err, exp_err);
            if (exp_q.size() != 0) chk("head", dec, exp_q[0]);
        end
    end

    // ---------------- directed stimulus ----------------
    logic [19:0] vpat = 20'b1101_0111_1011_1110_1101;
    logic [19:0] rpat = 20'b0110_1101_0110_1011_0101;
    logic [63:0] w9;

    initial begin
        vec_count  = 0;
        miss_count = 0;
        exp_err    = 1'b0;
        checking   = 1'b0;
        step(1'b0, 64'd0, 1'b0, 1'b1);
        step(1'b0, 64'd0, 1'b0, 1'b1);
        checking = 1'b1;

        // reset state
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_ready", iq_if.instr_ready_o, 1);
        chk("rst_err", err, 0);
        chk("rst_dec", dec, 0);

        // single push, decode check
        step(1'b1, mk(5, 64, 1, 255, 12, 34), 1'b0, 1'b0);
        chk("push1_empty", empty, 0);
        chk("push1_v1", dec.v_dim1, 3);
        chk("push1_u1", dec.u_dim1, 0);
        chk("push1_it1", dec.iter_dim1, 15);
        chk("push1_rd", dec.ub_rd_addr, 12);
        pop_one();
        chk("pop1_empty", empty, 1);

        // pop on empty
        pop_one();
        chk("pop_empty_count", count, 0);
        chk("pop_empty_empty", empty, 1);

        // fill to full, hold ninth word, drain in order
        for (int k = 1; k <= 8; k++) step(1'b1, mk(k, 16 * k, k, 8 * k, 100 * k, 7 * k), 1'b0, 1'b0);
        chk("full_count", count, 8);
        chk("full_ready", iq_if.instr_ready_o, 0);
        w9 = mk(1, 200, 20, 30, 999, 111);
        step(1'b1, w9, 1'b0, 1'b0);
        chk("held_count", count, 8);
        chk("drain_head1", dec.v_dim, 16);
        step(1'b1, w9, 1'b1, 1'b0);
        chk("full_pop_count", count, 7);
        chk("drain_head2", dec.v_dim, 32);
        step(1'b1, w9, 1'b1, 1'b0);
        chk("pushpop_full_count", count, 7);
        for (int k = 3; k <= 8; k++) begin
            chk("drain_head", dec.v_dim, 16 * k);
            pop_one();
        end
        chk("drain_w9", dec.v_dim, 200);
        pop_one();
        chk("drain_done", empty, 1);

        // simultaneous push and pop at count 3, then mixed traffic over wrap
        for (int k = 1; k <= 3; k++) step(1'b1, mk(k, k, k, k, k, k), 1'b0, 1'b0);
        step(1'b1, mk(7, 9, 9, 9, 9, 9), 1'b1, 1'b0);
        chk("pushpop3_count", count, 3);
        chk("pushpop3_head", dec.v_dim, 2);
        for (int i = 0; i < 20; i++)
            step(vpat[i], mk(i, i + 1, 2 * i + 1, 255 - i, i, 4095 - i), rpat[i], 1'b0);

        // reset mid-operation with concurrent push and pop
        while (exp_q.size() > 0) pop_one();
        for (int k = 1; k <= 5; k++) step(1'b1, mk(k, 50, 60, 70, k, k), 1'b0, 1'b0);
        chk("five_count", count, 5);
        step(1'b1, mk(3, 10, 10, 10, 1, 1), 1'b1, 1'b1);
        chk("midrst_count", count, 0);
        chk("midrst_empty", empty, 1);

        // zero dimension
        step(1'b1, mk(2, 32, 0, 16, 5, 6), 1'b0, 1'b0);
`ifdef IQ_ILLEGAL_CHECK_EN
        chk("ill_err", err, 1);
        chk("ill_count", count, 0);
        step(1'b1, mk(2, 32, 8, 16, 5, 6) | 64'h8000_0000_0000_0000, 1'b0, 1'b0);
        chk("rsvd_err", err, 1);
        idle();
        chk("ill_err_clear", err, 0);
`else
        chk("zero_count", count, 1);
        chk("zero_u1", dec.u_dim1, 7'h7F);
        chk("zero_v1", dec.v_dim1, 1);
        pop_one();
`endif
        idle();
        idle();
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end
endmodule

// File: doc/instruction_decode_queue.md
INSTRUCTION_DECODE_QUEUE -- requirements
Module: instruction_decode_queue

Interface
REQ-001 SHALL have parameter MUL_SIZE, default from tpu_package, systolic array edge; power of two, >=2.
REQ-002 SHALL have parameter IQ_DEPTH, default 8, queue entries; power of two, >=2.
REQ-003 SHALL have port clk_i  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port instr_valid_i  input  1  host offers a raw instruction word.
REQ-006 SHALL have port instr_word_i  input  64  raw word: [2:0] MAC_op, [10:3] V_dim, [18:11] U_dim, [26:19] ITER_dim, [38:27] UB read start address, [50:39] UB write start address, [63:51] reserved.
REQ-007 SHALL have port instr_ready_o  output  1  queue can accept a word this cycle.
REQ-008 SHALL have port read_instruction_i  input  1  consumer pops the head entry.
REQ-009 SHALL have port decoded_instruction_o  output  decoded_instr_t  head entry, show-ahead.
REQ-010 SHALL have port iq_empty_o  output  1  no valid entry at head.
REQ-011 SHALL have port iq_count_o  output  $clog2(IQ_DEPTH)+1  current occupancy.
REQ-012 SHALL have port err_illegal_o  output  1  one-cycle pulse when an offered word is rejected.

Function
REQ-013 SHALL accept a word on any cycle with instr_valid_i=1 and instr_ready_o=1; instr_ready_o SHALL equal (iq_count_o != IQ_DEPTH), independent of read_instruction_i.
REQ-014 SHALL decode at write time and store decoded_instr_t: MAC_op, V_dim, U_dim, ITER_dim and both UB addresses copied bit-exact.
REQ-015 SHALL compute V_dim1, U_dim1, ITER_dim1 as (dim - 1) >> log2(MUL_SIZE), truncated to 7 bits (tile count minus one).
REQ-016 SHALL deassert iq_empty_o and present the new head on decoded_instruction_o in the cycle after acceptance into an empty queue (1-cycle latency).
REQ-017 SHALL, when read_instruction_i=1 and iq_empty_o=0, retire the head; the next entry (or empty) is visible the following cycle.
REQ-018 SHALL ignore read_instruction_i while iq_empty_o=1; no pointer or count change.
REQ-019 SHALL, on simultaneous accept and pop with the queue non-empty, keep iq_count_o unchanged and preserve FIFO order.
REQ-020 SHALL, on simultaneous accept and pop with the queue empty, store the word and ignore the pop.
REQ-021 SHALL, on simultaneous accept and pop with the queue full, not accept (instr_ready_o=0) but still retire the head.
REQ-022 SHALL wrap read/write pointers modulo IQ_DEPTH without losing or duplicating entries.
REQ-023 SHALL hold decoded_instruction_o stable while iq_empty_o=0 and no pop occurs; its value while empty is don't-care.
REQ-024 SHALL drive a word offered with instr_ready_o=0 nowhere (host must hold it); err_illegal_o SHALL NOT assert for it.

Reset
REQ-025 SHALL, while rst_i=1 at a clock edge, clear pointers and count: iq_count_o=0, iq_empty_o=1, instr_ready_o=1 in the next cycle, err_illegal_o=0, decoded_instruction_o='0.
REQ-026 SHALL discard all stored entries on reset asserted mid-operation; concurrent push and pop in that cycle are ignored.

Configuration
REQ-027 SHALL support macro IQ_ILLEGAL_CHECK_EN: defined -> a word with V_dim, U_dim or ITER_dim equal to 0, or reserved bits nonzero, SHALL be consumed (ready handshake completes), not stored, and err_illegal_o pulsed for one cycle; undefined -> every accepted word stored, err_illegal_o tied 0, dim=0 decodes to dim1=7'h7F.

Verification (MUL_SIZE=16, IQ_DEPTH=8)
REQ-028 SHALL cover: push V_dim=64,U_dim=1,ITER_dim=255 -> next cycle iq_empty_o=0, V_dim1=3, U_dim1=0, ITER_dim1=15.
REQ-029 SHALL cover: 8 pushes, no pops -> iq_count_o=8, instr_ready_o=0; 9th word held, popping returns words 1..8 in order.
REQ-030 SHALL cover: queue count 3, push and pop same cycle -> count stays 3; 20 mixed ops -> order matches scoreboard across pointer wrap.
REQ-031 SHALL cover: pop on empty queue -> iq_count_o stays 0, iq_empty_o stays 1.
REQ-032 SHALL cover: 5 entries queued, rst_i pulsed with simultaneous push -> next cycle iq_count_o=0, iq_empty_o=1.
REQ-033 SHALL cover: with IQ_ILLEGAL_CHECK_EN, push U_dim=0 -> err_illegal_o=1 one cycle, iq_count_o unchanged; without macro -> stored, U_dim1=7'h7F.
